// File: rtl/uart_pkg.sv
// Shared definitions for uart_core: register map, STATUS/CONTROL bit positions, FSM states.
// Optional parity support is selected with the UART_PARITY_EN macro.
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'b00;
  localparam logic [1:0] REG_STATUS = 2'b01;
  localparam logic [1:0] REG_CTRL   = 2'b10;
  localparam logic [1:0] REG_DIV    = 2'b11;

  localparam int ST_TX_BUSY    = 0;
  localparam int ST_RX_VALID   = 1;
  localparam int ST_OVERRUN    = 2;
  localparam int ST_FRAME_ERR  = 3;
  localparam int ST_PARITY_ERR = 4;

  localparam int CTRL_TX_START = 0;
  localparam int CTRL_CLR_ERR  = 1;
  localparam int CTRL_PAR_ODD  = 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // A divisor of zero behaves as one clock per bit.
  function automatic logic [7:0] eff_div(input logic [7:0] d);
    return (d == 8'd0) ? 8'd1 : d;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// Receive path of uart_core: rx synchroniser, start-bit qualification, mid-bit sampling.
// Parity checking is compiled in only when UART_PARITY_EN is defined.
module uart_rx
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic [7:0] div,
`ifdef UART_PARITY_EN
  input  logic       par_odd,
  output logic       par_err,
`endif
  output logic       done,
  output logic [7:0] data,
  output logic       frame_err
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s, rx_prev_q;
  state_t                 state_q, state_d;
  logic [7:0]             cnt_q, sh_q;
  logic [2:0]             idx_q;
  logic                   mid, last;

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign mid  = (cnt_q == (div >> 1));
  assign last = (cnt_q >= div - 8'd1);
  assign data = sh_q;

  // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
      state_q   <= IDLE;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx};
      rx_prev_q <= rx_s;
      state_q   <= state_d;
    end
  end

  // NOTE: state_d gets its default first, so no path through the case can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (rx_prev_q && !rx_s) state_d = START;
      START:  if (mid && rx_s) state_d = IDLE;
              else if (last) state_d = DATA;
`ifdef UART_PARITY_EN
      DATA:   if (last && idx_q == 3'd7) state_d = PARITY;
`else
      DATA:   if (last && idx_q == 3'd7) state_d = STOP;
`endif
      PARITY: if (last) state_d = STOP;
      STOP:   if (mid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      sh_q      <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state_q == IDLE || last) cnt_q <= '0;
      else                         cnt_q <= cnt_q + 8'd1;
      if (state_q == IDLE) idx_q <= '0;
      if (state_q == DATA) begin
        if (mid)  sh_q  <= {rx_s, sh_q[7:1]};
        if (last) idx_q <= idx_q + 3'd1;
      end
`ifdef UART_PARITY_EN
      if (state_q == PARITY && mid) par_err <= rx_s ^ (^sh_q) ^ par_odd;
`endif
      // Leave at mid-stop so a following start edge is never missed.
      if (state_q == STOP && mid) begin
        done      <= 1'b1;
        frame_err <= !rx_s;
      end
    end
  end

endmodule

// File: rtl/uart_core.sv
// Memory-mapped 8-bit UART: register file, TX serialiser, uart_rx instance.
// Define UART_PARITY_EN to add a parity bit (even, or odd via CONTROL bit2).
module uart_core
  import uart_pkg::*;
#(
  parameter int DEFAULT_DIV = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       writeEnable,
  input  logic       readEnable,
  input  logic [1:0] regSelect,
  input  logic [7:0] writeData,
  input  logic       rx,
  output logic [7:0] Data,
  output logic       tx
);

  logic       wr_data, wr_ctrl, wr_div, rd_data, tx_start, clr_err;
  logic [7:0] hold_q, div_q, div_eff, rx_buf_q, rx_data;
  logic       rx_valid_q, overrun_q, frame_q, rx_done, rx_frame_err;
  logic       par_odd, parity_err;
  state_t     tx_state_q, tx_state_d;
  logic [7:0] tx_cnt_q, bit_div_q, tx_sh_q;
  logic [2:0] tx_idx_q;
  logic       tx_last;

  assign wr_data  = writeEnable && regSelect == REG_DATA;
  assign wr_ctrl  = writeEnable && regSelect == REG_CTRL;
  assign wr_div   = writeEnable && regSelect == REG_DIV;
  assign rd_data  = readEnable && regSelect == REG_DATA;
  assign tx_start = wr_ctrl && writeData[CTRL_TX_START] && tx_state_q == IDLE;
  assign clr_err  = wr_ctrl && writeData[CTRL_CLR_ERR];
  assign div_eff  = eff_div(div_q);
  assign tx_last  = (tx_cnt_q == bit_div_q - 8'd1);

`ifdef UART_PARITY_EN
  logic par_odd_q, parity_q, rx_par_err, tx_par_q;
  assign par_odd    = par_odd_q;
  assign parity_err = parity_q;
`else
  assign par_odd    = 1'b0;
  assign parity_err = 1'b0;
`endif

  uart_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .div       (div_eff),
`ifdef UART_PARITY_EN
    .par_odd   (par_odd),
    .par_err   (rx_par_err),
`endif
    .done      (rx_done),
    .data      (rx_data),
    .frame_err (rx_frame_err)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q     <= '0;
      div_q      <= 8'(DEFAULT_DIV);
      rx_buf_q   <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      frame_q    <= 1'b0;
`ifdef UART_PARITY_EN
      par_odd_q  <= 1'b0;
      parity_q   <= 1'b0;
`endif
    end else begin
      if (wr_data) hold_q <= writeData;
      if (wr_div)  div_q  <= writeData;
      if (rx_done) rx_buf_q <= rx_data;
      // A completing byte outranks a same-cycle read of the buffer.
      if (rx_done)      rx_valid_q <= 1'b1;
      else if (rd_data) rx_valid_q <= 1'b0;
      if (rx_done && rx_valid_q)   overrun_q <= 1'b1;
      else if (clr_err)            overrun_q <= 1'b0;
      if (rx_done && rx_frame_err) frame_q   <= 1'b1;
      else if (clr_err)            frame_q   <= 1'b0;
`ifdef UART_PARITY_EN
      if (wr_ctrl) par_odd_q <= writeData[CTRL_PAR_ODD];
      if (rx_done && rx_par_err)   parity_q  <= 1'b1;
      else if (clr_err)            parity_q  <= 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tx_state_q <= IDLE;
    else        tx_state_q <= tx_state_d;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      IDLE:   if (tx_start) tx_state_d = START;
      START:  if (tx_last) tx_state_d = DATA;
`ifdef UART_PARITY_EN
      DATA:   if (tx_last && tx_idx_q == 3'd7) tx_state_d = PARITY;
`else
      DATA:   if (tx_last && tx_idx_q == 3'd7) tx_state_d = STOP;
`endif
      PARITY: if (tx_last) tx_state_d = STOP;
      STOP:   if (tx_last) tx_state_d = IDLE;
      default: tx_state_d = IDLE;
    endcase
  end

  // tx is registered with the value of the bit that starts at this edge; the
  // per-bit length is re-latched at each boundary so DIV writes apply to the next bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx        <= 1'b1;
      tx_cnt_q  <= '0;
      bit_div_q <= '0;
      tx_sh_q   <= '0;
      tx_idx_q  <= '0;
`ifdef UART_PARITY_EN
      tx_par_q  <= 1'b0;
`endif
    end else if (tx_state_q == IDLE) begin
      tx_cnt_q <= '0;
      tx_idx_q <= '0;
      if (tx_start) begin
        tx        <= 1'b0;
        tx_sh_q   <= hold_q;
        bit_div_q <= div_eff;
`ifdef UART_PARITY_EN
        tx_par_q  <= (^hold_q) ^ par_odd;
`endif
      end
    end else if (tx_last) begin
      tx_cnt_q  <= '0;
      bit_div_q <= div_eff;
      case (tx_state_q)
        START: tx <= tx_sh_q[0];
        DATA: begin
          tx_sh_q  <= tx_sh_q >> 1;
          tx_idx_q <= tx_idx_q + 3'd1;
`ifdef UART_PARITY_EN
          tx       <= (tx_idx_q == 3'd7) ? tx_par_q : tx_sh_q[1];
`else
          tx       <= (tx_idx_q == 3'd7) ? 1'b1 : tx_sh_q[1];
`endif
        end
        default: tx <= 1'b1;
      endcase
    end else begin
      tx_cnt_q <= tx_cnt_q + 8'd1;
    end
  end

  always_comb begin
    Data = 8'h00;
    case (regSelect)
      REG_DATA: Data = rx_buf_q;
      REG_STATUS: begin
        Data[ST_TX_BUSY]    = (tx_state_q != IDLE);
        Data[ST_RX_VALID]   = rx_valid_q;
        Data[ST_OVERRUN]    = overrun_q;
        Data[ST_FRAME_ERR]  = frame_q;
        Data[ST_PARITY_ERR] = parity_err;
      end
      REG_CTRL: Data[CTRL_PAR_ODD] = par_odd;
      default:  Data = div_q;
    endcase
  end

endmodule

// File: tb/tb_uart_core.sv
// Directed self-checking bench for uart_core (default 8N1 build): register vectors,
// TX frame shapes, RX reception, overrun, frame error and glitch rejection.
module tb_uart_core;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       writeEnable = 1'b0;
  logic       readEnable = 1'b0;
  logic [1:0] regSelect = 2'b00;
  logic [7:0] writeData = 8'h00;
  logic       rx = 1'b1;
  logic [7:0] Data;
  logic       tx;

  int checks = 0;
  int errors = 0;

  uart_core #(.DEFAULT_DIV(2), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .writeEnable (writeEnable),
    .readEnable  (readEnable),
    .regSelect   (regSelect),
    .writeData   (writeData),
    .rx          (rx),
    .Data        (Data),
    .tx          (tx)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    string      name;
    logic [1:0] waddr;
    logic [7:0] wdata;
    logic [1:0] raddr;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] addr, input logic [7:0] d);
    @(negedge clk);
    writeEnable = 1'b1;
    regSelect   = addr;
    writeData   = d;
    @(negedge clk);
    writeEnable = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [1:0] addr, input logic [7:0] exp);
    @(negedge clk);
    regSelect = addr;
    #1;
    check(name, Data, exp);
  endtask

  task automatic pop();
    @(negedge clk);
    regSelect  = REG_DATA;
    readEnable = 1'b1;
    @(negedge clk);
    readEnable = 1'b0;
  endtask

  // Starts a frame and checks tx every cycle against the ideal 8N1 waveform.
  task automatic tx_frame(input string name, input logic [7:0] b, input int div, input bit inject);
    int   busy_cnt = 0;
    int   bitn;
    logic e;
    wr(REG_CTRL, 8'h01);
    for (int c = 1; c <= 10 * div + 6; c++) begin
      writeEnable = 1'b0;
      regSelect   = REG_STATUS;
      #1;
      bitn = (c - 1) / div;
      if (bitn == 0)      e = 1'b0;
      else if (bitn <= 8) e = b[bitn-1];
      else                e = 1'b1;
      check($sformatf("%s tx c%0d", name, c), tx, e);
      if (Data[ST_TX_BUSY]) busy_cnt++;
      if (inject && c == 5) begin
        writeEnable = 1'b1; regSelect = REG_CTRL; writeData = 8'h01;
      end
      if (inject && c == 7) begin
        writeEnable = 1'b1; regSelect = REG_DATA; writeData = 8'h55;
      end
      @(negedge clk);
    end
    writeEnable = 1'b0;
    check({name, " busy cycles"}, busy_cnt, 10 * div);
  endtask

  task automatic rx_send(input logic [7:0] b, input int div, input logic stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      repeat (div) @(negedge clk);
    end
    rx = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{"div write 05",       REG_DIV,    8'h05, REG_DIV,    8'h05};
    vecs[1] = '{"div write 00",       REG_DIV,    8'h00, REG_DIV,    8'h00};
    vecs[2] = '{"status read-only",   REG_STATUS, 8'hFF, REG_STATUS, 8'h00};
    vecs[3] = '{"ctrl reserved",      REG_CTRL,   8'hF8, REG_CTRL,   8'h00};
    vecs[4] = '{"data write hold",    REG_DATA,   8'h77, REG_DATA,   8'h00};
    vecs[5] = '{"div restore 02",     REG_DIV,    8'h02, REG_DIV,    8'h02};

    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Reset in the middle of a frame of zeros.
    wr(REG_DATA, 8'h00);
    wr(REG_CTRL, 8'h01);
    repeat (4) @(negedge clk);
    #1;
    check("tx low before reset", tx, 1'b0);
    reset = 1'b0;
    #1;
    check("tx high in reset", tx, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    rd_check("reset status", REG_STATUS, 8'h00);
    rd_check("reset div",    REG_DIV,    8'h02);
    rd_check("reset data",   REG_DATA,   8'h00);
    rd_check("reset ctrl",   REG_CTRL,   8'h00);
    check("tx idle after reset", tx, 1'b1);

    for (int i = 0; i < 6; i++) begin
      wr(vecs[i].waddr, vecs[i].wdata);
      rd_check(vecs[i].name, vecs[i].raddr, vecs[i].exp);
    end

    // 0xAA at DIV=2, with an ignored TX_START and a hold update mid-frame.
    wr(REG_DATA, 8'hAA);
    tx_frame("frame AA", 8'hAA, 2, 1'b1);
    tx_frame("frame 55", 8'h55, 2, 1'b0);

    // DIV=0 behaves as one clock per bit.
    wr(REG_DATA, 8'hC3);
    wr(REG_DIV, 8'h00);
    tx_frame("frame C3 div0", 8'hC3, 1, 1'b0);

    wr(REG_DIV, 8'h04);
    rx_send(8'h3C, 4, 1'b1);
    rd_check("rx 3C status", REG_STATUS, 8'h02);
    rd_check("rx 3C data",   REG_DATA,   8'h3C);
    pop();
    rd_check("rx popped status", REG_STATUS, 8'h00);
    rd_check("rx popped data",   REG_DATA,   8'h3C);

    rx_send(8'h11, 4, 1'b1);
    rx_send(8'hA5, 4, 1'b1);
    rd_check("overrun status", REG_STATUS, 8'h06);
    rd_check("overrun data",   REG_DATA,   8'hA5);
    wr(REG_CTRL, 8'h02);
    rd_check("clr overrun status", REG_STATUS, 8'h02);
    pop();
    rd_check("overrun popped", REG_STATUS, 8'h00);

    rx_send(8'h5A, 4, 1'b0);
    rd_check("frame err status", REG_STATUS, 8'h0A);
    rd_check("frame err data",   REG_DATA,   8'h5A);
    wr(REG_CTRL, 8'h02);
    rd_check("clr frame err", REG_STATUS, 8'h02);
    pop();
    rd_check("frame err popped", REG_STATUS, 8'h00);

    // One-clock low glitch must be rejected at the start-bit re-check.
    @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (50) @(negedge clk);
    rd_check("glitch status", REG_STATUS, 8'h00);
    rd_check("glitch data",   REG_DATA,   8'h5A);
    check("tx idle at end", tx, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
